// File: rtl/axi_core_master.sv
// Single-outstanding AXI4 master: core requests become INCR read bursts or
// single-beat writes; read beats and write completions are reported back.
module axi_core_master #(
  parameter int                 ID_BITS   = 4,
  parameter logic [ID_BITS-1:0] MASTER_ID = 4'd0,
  parameter int                 ADDR_BITS = 32,
  parameter int                 DATA_BITS = 32,
  parameter int                 LEN_BITS  = 4
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  // core request port
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_BITS-1:0]   req_addr,
  input  logic [DATA_BITS-1:0]   req_wdata,
  input  logic [DATA_BITS/8-1:0] req_wstrb,
  input  logic [LEN_BITS-1:0]    req_len,
  // core response port
  output logic                   rsp_valid,
  output logic [DATA_BITS-1:0]   rsp_rdata,
  output logic                   rsp_last,
  output logic                   rsp_err,
  // AXI write address
  output logic [ID_BITS-1:0]     AWID,
  output logic [ADDR_BITS-1:0]   AWADDR,
  output logic [7:0]             AWLEN,
  output logic [2:0]             AWSIZE,
  output logic [1:0]             AWBURST,
  output logic                   AWVALID,
  input  logic                   AWREADY,
  // AXI write data
  output logic [DATA_BITS-1:0]   WDATA,
  output logic [DATA_BITS/8-1:0] WSTRB,
  output logic                   WLAST,
  output logic                   WVALID,
  input  logic                   WREADY,
  // AXI write response
  input  logic [ID_BITS-1:0]     BID,
  input  logic [1:0]             BRESP,
  input  logic                   BVALID,
  output logic                   BREADY,
  // AXI read address
  output logic [ID_BITS-1:0]     ARID,
  output logic [ADDR_BITS-1:0]   ARADDR,
  output logic [7:0]             ARLEN,
  output logic [2:0]             ARSIZE,
  output logic [1:0]             ARBURST,
  output logic                   ARVALID,
  input  logic                   ARREADY,
  // AXI read data
  input  logic [ID_BITS-1:0]     RID,
  input  logic [DATA_BITS-1:0]   RDATA,
  input  logic [1:0]             RRESP,
  input  logic                   RLAST,
  input  logic                   RVALID,
  output logic                   RREADY
);

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic [DATA_BITS-1:0]    wdata_q, wdata_d;
  logic [DATA_BITS/8-1:0]  wstrb_q, wstrb_d;
  logic [LEN_BITS-1:0]     len_q, len_d;
  logic [LEN_BITS-1:0]     beat_q, beat_d;
  logic                    over_q, over_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;

  logic                    aw_hs, w_hs;
  logic                    unused_resp_lsb;

  assign unused_resp_lsb = ^{RRESP[0], BRESP[0]};

  // Payload comes straight from the latched registers, so it cannot move
  // while a VALID is waiting for its READY.
  assign ARID    = MASTER_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = 8'(len_q);
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;
  assign AWID    = MASTER_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = 8'd0;
  assign AWSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign WLAST   = 1'b1;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the case statement leaves it unassigned (no latches).
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    len_d     = len_q;
    beat_d    = beat_q;
    over_d    = over_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_last  = 1'b0;
    rsp_err   = 1'b0;
    ARVALID   = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    BREADY    = 1'b0;
    RREADY    = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = !ARESET;
        if (req_valid && !ARESET) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          len_d     = req_len;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_write ? AW_W : AR;
        end
      end
      AR: begin
        ARVALID = 1'b1;
        if (ARREADY) begin
          beat_d  = '0;
          over_d  = 1'b0;
          state_d = R;
        end
      end
      R: begin
        RREADY = 1'b1;
        if (RVALID) begin
          rsp_valid = 1'b1;
          rsp_rdata = RDATA;
          rsp_last  = RLAST;
          // over_q marks that the beat at index len has already gone by.
          rsp_err   = RRESP[1] || (RID != MASTER_ID) || over_q ||
                      (RLAST && (beat_q != len_q));
          beat_d    = beat_q + 1'b1;
          if (beat_q == len_q) over_d = 1'b1;
          if (RLAST) state_d = IDLE;
        end
      end
      AW_W: begin
        AWVALID   = !aw_done_q;
        WVALID    = !w_done_q;
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) state_d = B;
      end
      B: begin
        BREADY = 1'b1;
        if (BVALID) begin
          rsp_valid = 1'b1;
          rsp_last  = 1'b1;
          rsp_err   = BRESP[1] || (BID != MASTER_ID);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // flops sample their _d values from the same clock edge.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      over_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      over_q    <= over_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi_core_master.sv
// Directed bench for axi_core_master: inputs change 1 ns after the rising
// edge and outputs are sampled 1 ns later, away from the active edge.
module tb_axi_core_master;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb, req_len;
  logic        rsp_valid, rsp_last, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  int checks = 0;
  int failures = 0;

  always #5 ACLK = ~ACLK;

  axi_core_master dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
    .rsp_err(rsp_err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
    .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Presents a request for one cycle; checks it is accepted on that edge.
  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb,
                       input logic [3:0] len, input string name);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_wdata = data; req_wstrb = strb; req_len = len;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s req_ready: got %b want 1", name, req_ready);
    end
    tick();
    req_valid = 1'b0;
  endtask

  // Presents one R beat, checks the combinational response, then clocks it.
  task automatic r_beat(input logic [31:0] data, input logic [1:0] resp,
                        input logic [3:0] id, input logic last,
                        input logic exp_last, input logic exp_err,
                        input string name);
    RVALID = 1'b1; RDATA = data; RRESP = resp; RID = id; RLAST = last;
    #1;
    checks++;
    if ({RREADY, rsp_valid, rsp_rdata, rsp_last, rsp_err} !==
        {1'b1, 1'b1, data, exp_last, exp_err}) begin
      failures++;
      $display("FAIL %s beat: got rready=%b v=%b d=%h last=%b err=%b want 1 1 %h %b %b",
               name, RREADY, rsp_valid, rsp_rdata, rsp_last, rsp_err,
               data, exp_last, exp_err);
    end
    tick();
    RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00; RID = 4'd0;
  endtask

  task automatic expect_idle(input string name);
    #1;
    checks++;
    if ({req_ready, rsp_valid, RREADY, BREADY} !== 4'b1000) begin
      failures++;
      $display("FAIL %s idle: got ready=%b v=%b rready=%b bready=%b want 1 0 0 0",
               name, req_ready, rsp_valid, RREADY, BREADY);
    end
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    #1;
    checks++;
    if ({req_ready, ARVALID, AWVALID, WVALID, BREADY, RREADY, rsp_valid,
         rsp_last, rsp_err, rsp_rdata, ARADDR, WDATA, ARLEN} !== '0) begin
      failures++;
      $display("FAIL reset outputs: got ready=%b ar=%b aw=%b w=%b b=%b r=%b v=%b araddr=%h wdata=%h arlen=%h want all 0",
               req_ready, ARVALID, AWVALID, WVALID, BREADY, RREADY,
               rsp_valid, ARADDR, WDATA, ARLEN);
    end
    tick();
    ARESET = 1'b0;
    tick();
    expect_idle("after_reset");
  endtask

  task automatic test_read_single();
    issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, 4'd0, "read_single");
    for (int c = 0; c < 4; c++) begin
      ARREADY = (c == 3);
      #1;
      checks++;
      if ({ARVALID, ARADDR, ARLEN, ARID, ARSIZE, ARBURST, req_ready} !==
          {1'b1, 32'h0000_0010, 8'd0, 4'd0, 3'b010, 2'b01, 1'b0}) begin
        failures++;
        $display("FAIL read_single ar cycle %0d: got v=%b addr=%h len=%h id=%h size=%b burst=%b ready=%b want 1 00000010 00 0 010 01 0",
                 c, ARVALID, ARADDR, ARLEN, ARID, ARSIZE, ARBURST, req_ready);
      end
      tick();
    end
    ARREADY = 1'b0;
    #1;
    checks++;
    if (ARVALID !== 1'b0) begin
      failures++;
      $display("FAIL read_single arvalid_drop: got %b want 0", ARVALID);
    end
    r_beat(32'hDEAD_BEEF, 2'b00, 4'd0, 1'b1, 1'b1, 1'b0, "read_single");
    expect_idle("read_single");
  endtask

  task automatic test_burst_read();
    issue(1'b0, 32'h0000_0100, 32'h0, 4'h0, 4'd3, "burst");
    ARREADY = 1'b1;
    #1;
    checks++;
    if ({ARVALID, ARLEN, ARADDR} !== {1'b1, 8'd3, 32'h0000_0100}) begin
      failures++;
      $display("FAIL burst ar: got v=%b len=%h addr=%h want 1 03 00000100",
               ARVALID, ARLEN, ARADDR);
    end
    tick();
    ARREADY = 1'b0;
    r_beat(32'hA0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, "burst0");
    r_beat(32'hA1, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, "burst1");
    #1;
    checks++;
    if ({rsp_valid, RREADY, req_ready} !== 3'b010) begin
      failures++;
      $display("FAIL burst gap: got v=%b rready=%b ready=%b want 0 1 0",
               rsp_valid, RREADY, req_ready);
    end
    tick();
    r_beat(32'hA2, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, "burst2");
    r_beat(32'hA3, 2'b00, 4'd0, 1'b1, 1'b1, 1'b0, "burst3");
    expect_idle("burst");
  endtask

  task automatic test_write();
    issue(1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011, 4'd7, "write");
    WREADY = 1'b1; AWREADY = 1'b0;
    #1;
    checks++;
    if ({AWVALID, WVALID, AWADDR, AWLEN, AWSIZE, AWBURST, WDATA, WSTRB, WLAST} !==
        {1'b1, 1'b1, 32'h20, 8'd0, 3'b010, 2'b01, 32'h1234_5678, 4'b0011, 1'b1}) begin
      failures++;
      $display("FAIL write aw_w: got aw=%b w=%b addr=%h len=%h size=%b burst=%b data=%h strb=%b last=%b",
               AWVALID, WVALID, AWADDR, AWLEN, AWSIZE, AWBURST, WDATA, WSTRB, WLAST);
    end
    tick();
    WREADY = 1'b0;
    for (int c = 0; c < 2; c++) begin
      AWREADY = (c == 1);
      #1;
      checks++;
      if ({AWVALID, WVALID, BREADY} !== 3'b100) begin
        failures++;
        $display("FAIL write w_done cycle %0d: got aw=%b w=%b bready=%b want 1 0 0",
                 c, AWVALID, WVALID, BREADY);
      end
      tick();
    end
    AWREADY = 1'b0;
    BVALID = 1'b1; BRESP = 2'b00; BID = 4'd0;
    #1;
    checks++;
    if ({AWVALID, BREADY, rsp_valid, rsp_last, rsp_err, rsp_rdata} !==
        {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL write b: got aw=%b bready=%b v=%b last=%b err=%b d=%h want 0 1 1 1 0 0",
               AWVALID, BREADY, rsp_valid, rsp_last, rsp_err, rsp_rdata);
    end
    tick();
    BVALID = 1'b0;
    expect_idle("write");
  endtask

  task automatic test_decerr();
    issue(1'b0, 32'hF000_0000, 32'h0, 4'h0, 4'd0, "decerr_rd");
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    r_beat(32'h0, 2'b10, 4'd0, 1'b1, 1'b1, 1'b1, "decerr_rd");
    expect_idle("decerr_rd");
    // Write with AW and W accepted in the same cycle.
    issue(1'b1, 32'hF000_0004, 32'hCAFE_0000, 4'hF, 4'd0, "decerr_wr");
    AWREADY = 1'b1; WREADY = 1'b1;
    tick();
    AWREADY = 1'b0; WREADY = 1'b0;
    BVALID = 1'b1; BRESP = 2'b10; BID = 4'd0;
    #1;
    checks++;
    if ({AWVALID, WVALID, rsp_valid, rsp_last, rsp_err} !== 5'b00111) begin
      failures++;
      $display("FAIL decerr_wr b: got aw=%b w=%b v=%b last=%b err=%b want 0 0 1 1 1",
               AWVALID, WVALID, rsp_valid, rsp_last, rsp_err);
    end
    tick();
    BVALID = 1'b0; BRESP = 2'b00;
    expect_idle("decerr_wr");
  endtask

  task automatic test_early_last();
    issue(1'b0, 32'h0000_0200, 32'h0, 4'h0, 4'd3, "early_last");
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    r_beat(32'hB0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, "early0");
    r_beat(32'hB1, 2'b00, 4'd0, 1'b1, 1'b1, 1'b1, "early1");
    expect_idle("early_last");
    // Wrong RID flags the beat; a beat past len is flagged too.
    issue(1'b0, 32'h0000_0300, 32'h0, 4'h0, 4'd0, "bad_id");
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    r_beat(32'hC0, 2'b00, 4'd5, 1'b0, 1'b0, 1'b1, "bad_id");
    r_beat(32'hC1, 2'b00, 4'd0, 1'b1, 1'b1, 1'b1, "past_len");
    expect_idle("past_len");
  endtask

  task automatic test_reset_mid_read();
    issue(1'b0, 32'h0000_0400, 32'h0, 4'h0, 4'd3, "rst_mid");
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    r_beat(32'hD0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, "rst_mid0");
    r_beat(32'hD1, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, "rst_mid1");
    RVALID = 1'b1; RDATA = 32'hD2;
    ARESET = 1'b1;
    #1;
    checks++;
    if ({req_ready, ARVALID, AWVALID, WVALID, BREADY, RREADY, rsp_valid} !== 7'b0) begin
      failures++;
      $display("FAIL rst_mid outputs: got ready=%b ar=%b aw=%b w=%b b=%b r=%b v=%b want all 0",
               req_ready, ARVALID, AWVALID, WVALID, BREADY, RREADY, rsp_valid);
    end
    tick();
    RVALID = 1'b0;
    ARESET = 1'b0;
    expect_idle("rst_mid_release");
    issue(1'b0, 32'h0000_0500, 32'h0, 4'h0, 4'd0, "rst_fresh");
    ARREADY = 1'b1;
    #1;
    checks++;
    if ({ARVALID, ARADDR, ARLEN} !== {1'b1, 32'h0000_0500, 8'd0}) begin
      failures++;
      $display("FAIL rst_fresh ar: got v=%b addr=%h len=%h want 1 00000500 00",
               ARVALID, ARADDR, ARLEN);
    end
    tick();
    ARREADY = 1'b0;
    r_beat(32'h5555_AAAA, 2'b00, 4'd0, 1'b1, 1'b1, 1'b0, "rst_fresh");
    expect_idle("rst_fresh");
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; req_len = '0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00; BID = 4'd0;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0;
    RID = 4'd0;
    test_reset();
    test_read_single();
    test_burst_read();
    test_write();
    test_decerr();
    test_early_last();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_core_master.md
Name: axi_core_master

Overview:
- Single-outstanding AXI4 master that turns a simple core-side memory request port into AXI read bursts and single-beat writes.
- Sits between a CPU fetch/LSU port and the AXI interconnect.
- It is the initiator facing the interconnect's slaves, including the default slave that answers DECERR to unmapped addresses.
- Reports per-beat read data and write completion back to the core, with an error flag.

Parameters:
- MASTER_ID, 4'd0, value driven on ARID/AWID; expected on RID/BID.
- ID_BITS, 4, AXI master-side ID width.
- ADDR_BITS, 32, address width.
- DATA_BITS, 32, data width; STRB is DATA_BITS/8.
- LEN_BITS, 4, burst length field width.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  asynchronous reset, active-high
- req_valid  in  1  core request valid
- req_ready  out  1  core request accepted this cycle when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_BITS  byte address
- req_wdata  in  DATA_BITS  write data
- req_wstrb  in  DATA_BITS/8  write byte strobes
- req_len  in  LEN_BITS  read beats minus 1; ignored for writes
- rsp_valid  out  1  one-cycle pulse per read beat or per write completion
- rsp_rdata  out  DATA_BITS  read data; 0 for writes
- rsp_last  out  1  final response of the transaction
- rsp_err  out  1  error on this response
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out; AWREADY  in
- WDATA/WSTRB/WLAST/WVALID  out; WREADY  in
- BID/BRESP/BVALID  in; BREADY  out
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out; ARREADY  in
- RID/RDATA/RRESP/RLAST/RVALID  in; RREADY  out

Behaviour:
- Reset: state IDLE. All VALID/READY outputs are 0 and req_ready is 0 while ARESET is high. rsp_* are 0. Latched address, data and length registers are 0. Reset asserted mid-transaction returns to IDLE immediately; the bus-side transaction is abandoned.
- States: IDLE, AR, R, AW_W, B.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, wdata, wstrb and len.
  - If req_write=1, go to AW_W; otherwise go to AR.
- AR:
  - ARVALID=1 with ARID=MASTER_ID, ARADDR=latched addr, ARLEN=latched len, ARSIZE=3'b010, ARBURST=2'b01 (INCR).
  - Hold ARVALID and all AR fields stable until ARREADY.
  - On ARREADY, clear the beat counter and go to R.
- R:
  - RREADY=1.
  - Each RVALID cycle: rsp_valid=1 and rsp_rdata=RDATA, both combinational from the R channel.
  - rsp_err=1 on a beat if any of: RRESP[1]=1, RID≠MASTER_ID, or RLAST=1 while beat count≠len.
  - Beats beyond len are also flagged with rsp_err=1.
  - The beat counter increments per beat and wraps modulo 2^LEN_BITS.
  - rsp_last = RLAST. On an RLAST beat, go to IDLE.
- AW_W:
  - Assert AWVALID and WVALID together, with AWLEN=0, AWSIZE=3'b010, AWBURST=2'b01, WLAST=1.
  - Sticky aw_done and w_done flags are set on their respective handshakes; each VALID deasserts the cycle after its own handshake.
  - Both handshakes in the same cycle is legal.
  - When both are done (including the same cycle), go to B.
  - W accepted before AW is legal.
- B:
  - BREADY=1.
  - On BVALID: rsp_valid=1, rsp_last=1, rsp_err = BRESP[1] | (BID≠MASTER_ID). Go to IDLE.
- req_ready is 0 outside IDLE. A new request is accepted at the earliest in the cycle after the final response.
- Protocol: no VALID is ever withdrawn before its READY. Payload fields are constant while VALID is high.

Test Plan:
- Read, len=0, addr 0x0000_0010, ARREADY delayed 3 cycles, then R beat 0xDEADBEEF with RRESP=0 and RLAST → ARVALID high 4 cycles with ARLEN=0; one rsp_valid with rdata 0xDEADBEEF, last=1, err=0; req_ready back high the next cycle.
- Burst read, len=3, RVALID gapped (beats 0xA0..0xA3, idle cycle between beats 1 and 2) → four rsp_valid pulses in order; last only on 0xA3; err=0.
- Write 0x1234_5678, wstrb=4'b0011: WREADY asserted 2 cycles before AWREADY, BRESP=0 → WVALID drops after its handshake while AWVALID persists; single completion pulse with last=1, err=0.
- Unmapped address, interconnect default slave: read returns RRESP=2'b10 with RLAST; write returns BRESP=2'b10 → rsp_err=1 on each.
- Read len=3 with RLAST on beat 1 → err=1 on that beat, last=1, state returns to IDLE.
- ARESET pulsed during R after 2 of 4 beats → all VALID/READY outputs 0 immediately; after release req_ready=1 and a fresh read completes normally.
